// File: rtl/roce_tx_engine_if.sv
// Handshake and bus bundle for the RoCEv2 transmit engine: work requests in,
// AXI-Stream TX beats out, and the HBM read port.
interface roce_tx_engine_if #(
  parameter int MAX_QP = 16
);
  localparam int QP_W = $clog2(MAX_QP);

  logic              wr_valid;
  logic              wr_ready;
  logic [QP_W-1:0]   wr_qp;
  logic [31:0]       wr_raddr;
  logic [31:0]       wr_laddr;
  logic [7:0]        wr_len;

  logic [511:0]      axis_tx_data;
  logic              axis_tx_valid;
  logic              axis_tx_ready;
  logic              axis_tx_last;

  logic [31:0]       hbm_addr;
  logic              hbm_re;
  logic [511:0]      hbm_data_in;

  modport master (
    output wr_valid, wr_qp, wr_raddr, wr_laddr, wr_len,
    input  wr_ready,
    input  axis_tx_data, axis_tx_valid, axis_tx_last,
    output axis_tx_ready,
    input  hbm_addr, hbm_re,
    output hbm_data_in
  );

  modport slave (
    input  wr_valid, wr_qp, wr_raddr, wr_laddr, wr_len,
    output wr_ready,
    output axis_tx_data, axis_tx_valid, axis_tx_last,
    input  axis_tx_ready,
    output hbm_addr, hbm_re,
    input  hbm_data_in
  );
endinterface

// File: rtl/roce_tx_engine.sv
// RoCEv2 transmit engine: one header beat plus HBM-sourced payload per RDMA WRITE.
// Optional packet/beat counters are built when ROCE_TX_STATS_EN is defined.
module roce_tx_engine #(
  parameter int MAX_QP     = 16,
  parameter int HBM_RD_LAT = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  roce_tx_engine_if.slave     bus,
  input  logic                psn_clr,
  output logic                busy,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_beats
);
  localparam int QP_W = $clog2(MAX_QP);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t            state_reg, state_next;
  logic [QP_W-1:0]   qp_reg;
  logic [31:0]       raddr_reg;
  logic [31:0]       addr_reg;
  logic [7:0]        len_reg;
  logic [23:0]       psn_reg;
  logic [8:0]        issued_reg;
  logic [8:0]        sent_reg;
  logic [CW-1:0]     inflight_reg;
  logic [CW-1:0]     count_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic              vld_sr_reg [HBM_RD_LAT];
  logic [511:0]      fifo_mem [FIFO_DEPTH];
  logic [23:0]       psn_tab [MAX_QP];

  logic              wr_accept;
  logic              hdr_hs;
  logic              pop;
  logic              land;
  logic              issue;
  logic              pay_last;
  logic [CW:0]       credit;
  logic [511:0]      hdr_data;

  assign wr_accept = bus.wr_valid && (state_reg == IDLE);
  assign hdr_hs    = (state_reg == HDR) && bus.axis_tx_ready;
  assign pop       = (state_reg == PAY) && (count_reg != '0) && bus.axis_tx_ready;
  assign land      = vld_sr_reg[HBM_RD_LAT-1];
  assign pay_last  = (sent_reg + 9'd1) == {1'b0, len_reg};
  // Reads are only issued when the landing slot is already reserved in the FIFO.
  assign credit    = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign issue     = (state_reg != IDLE) && (issued_reg < {1'b0, len_reg}) &&
                     (credit < (CW+1)'(FIFO_DEPTH));

  assign bus.hbm_re   = issue;
  assign bus.hbm_addr = addr_reg;
  assign busy         = (state_reg != IDLE);

  always_comb begin
    hdr_data          = '0;
    hdr_data[7:0]     = 8'h0A;
    hdr_data[15:8]    = 8'(qp_reg);
    hdr_data[31:16]   = {8'h00, len_reg};
    hdr_data[63:32]   = raddr_reg;
    hdr_data[87:64]   = psn_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    bus.wr_ready      = 1'b0;
    bus.axis_tx_valid = 1'b0;
    bus.axis_tx_last  = 1'b0;
    bus.axis_tx_data  = '0;
    case (state_reg)
      IDLE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) state_next = HDR;
      end
      HDR: begin
        bus.axis_tx_valid = 1'b1;
        bus.axis_tx_data  = hdr_data;
        bus.axis_tx_last  = (len_reg == 8'd0);
        if (bus.axis_tx_ready) state_next = (len_reg == 8'd0) ? IDLE : PAY;
      end
      PAY: begin
        bus.axis_tx_valid = (count_reg != '0);
        bus.axis_tx_data  = fifo_mem[rd_ptr_reg];
        bus.axis_tx_last  = pay_last;
        if (pop && pay_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qp_reg       <= '0;
      raddr_reg    <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      psn_reg      <= '0;
      issued_reg   <= '0;
      sent_reg     <= '0;
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      if (wr_accept) begin
        qp_reg     <= bus.wr_qp;
        raddr_reg  <= bus.wr_raddr;
        addr_reg   <= bus.wr_laddr;
        len_reg    <= bus.wr_len;
        psn_reg    <= psn_tab[bus.wr_qp];
        issued_reg <= '0;
        sent_reg   <= '0;
      end else begin
        if (issue) begin
          addr_reg   <= addr_reg + 32'd64;
          issued_reg <= issued_reg + 9'd1;
        end
        if (pop) sent_reg <= sent_reg + 9'd1;
      end
      inflight_reg <= inflight_reg + CW'(issue) - CW'(land);
      count_reg    <= count_reg + CW'(land) - CW'(pop);
      if (land) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (land) fifo_mem[wr_ptr_reg] <= bus.hbm_data_in;
  end

  // Valid shift register mirrors the fixed HBM latency; reset drops late returns.
  genvar gi;
  generate
    for (gi = 0; gi < HBM_RD_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) vld_sr_reg[gi] <= 1'b0;
          else        vld_sr_reg[gi] <= issue;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) vld_sr_reg[gi] <= 1'b0;
          else        vld_sr_reg[gi] <= vld_sr_reg[gi-1];
        end
      end
    end

    for (gi = 0; gi < MAX_QP; gi++) begin : g_psn
      logic [23:0] psn_entry_reg;
      // Clear beats the header-handshake increment when both land together.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  psn_entry_reg <= '0;
        else if (psn_clr)                            psn_entry_reg <= '0;
        else if (hdr_hs && (qp_reg == QP_W'(gi)))    psn_entry_reg <= psn_reg + 24'd1;
      end
      assign psn_tab[gi] = psn_entry_reg;
    end
  endgenerate

`ifdef ROCE_TX_STATS_EN
  logic        tx_hs;
  logic [31:0] pkts_reg;
  logic [31:0] beats_reg;

  assign tx_hs = bus.axis_tx_valid && bus.axis_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkts_reg  <= '0;
      beats_reg <= '0;
    end else if (tx_hs) begin
      beats_reg <= beats_reg + 32'd1;
      if (bus.axis_tx_last) pkts_reg <= pkts_reg + 32'd1;
    end
  end

  assign stat_pkts  = pkts_reg;
  assign stat_beats = beats_reg;
`else
  assign stat_pkts  = '0;
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_roce_tx_engine.sv
// Directed bench for roce_tx_engine with a fixed-latency HBM model and a TX beat collector.
module tb_roce_tx_engine;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psn_clr = 1'b0;
  logic        busy;
  logic [31:0] stat_pkts, stat_beats;
  logic        rnd_mode = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  roce_tx_engine_if #(.MAX_QP(16)) bus ();

  roce_tx_engine #(.MAX_QP(16), .HBM_RD_LAT(L), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .psn_clr(psn_clr),
    .busy(busy), .stat_pkts(stat_pkts), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] a);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = a + 32'(i);
    return p;
  endfunction

  function automatic logic [511:0] hdr(input logic [3:0] qp, input logic [7:0] len,
                                       input logic [31:0] raddr, input logic [23:0] psn);
    logic [511:0] h;
    h = '0;
    h[7:0] = 8'h0A; h[15:8] = {4'h0, qp}; h[31:16] = {8'h00, len};
    h[63:32] = raddr; h[87:64] = psn;
    return h;
  endfunction

  // HBM model: data for a read issued in cycle c is presented during cycle c+L.
  typedef struct { logic [31:0] addr; int cyc; } iss_t;
  iss_t        iss[$];
  logic        hv [L+1];
  logic [31:0] ha [L+1];
  initial begin
    for (int i = 0; i <= L; i++) begin hv[i] = 1'b0; ha[i] = '0; end
    bus.hbm_data_in = '0;
    forever begin
      @(negedge clk);
      for (int i = L; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
      hv[0] = bus.hbm_re;
      ha[0] = bus.hbm_addr;
      if (bus.hbm_re) iss.push_back('{bus.hbm_addr, cyc});
      bus.hbm_data_in = hv[L] ? pat(ha[L]) : {16{32'hDEAD_BEEF}};
    end
  end

  initial begin
    bus.axis_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.axis_tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // TX collector plus the hold-while-stalled rule.
  typedef struct { logic [511:0] data; logic last; int cyc; } beat_t;
  beat_t        beats[$];
  logic         stall_prev = 1'b0;
  logic [511:0] stall_data;
  logic         stall_last;
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      check("hold_valid", bus.axis_tx_valid, 1);
      check("hold_data", bus.axis_tx_data, stall_data);
      check("hold_last", bus.axis_tx_last, stall_last);
    end
    stall_prev = rst_n && bus.axis_tx_valid && !bus.axis_tx_ready;
    stall_data = bus.axis_tx_data;
    stall_last = bus.axis_tx_last;
    if (rst_n && bus.axis_tx_valid && bus.axis_tx_ready)
      beats.push_back('{bus.axis_tx_data, bus.axis_tx_last, cyc});
  end

  task automatic send(input logic [3:0] qp, input logic [31:0] raddr, input logic [31:0] laddr,
                      input logic [7:0] len);
    int t = 0;
    @(negedge clk);
    while (!bus.wr_ready && t < 3000) begin @(negedge clk); t++; end
    if (!bus.wr_ready) check("wr_ready_timeout", 0, 1);
    bus.wr_valid = 1'b1; bus.wr_qp = qp; bus.wr_raddr = raddr;
    bus.wr_laddr = laddr; bus.wr_len = len;
    acc_cyc = cyc;
    @(negedge clk);
    check("wr_ready_busy", bus.wr_ready, 0);
    check("busy_high", busy, 1);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats.size() < n && t < 3000) begin @(posedge clk); t++; end
    if (beats.size() < n) check("beat_timeout", beats.size(), n);
  endtask

  task automatic expect_pkt(input logic [3:0] qp, input logic [31:0] raddr, input logic [31:0] laddr,
                            input logic [7:0] len, input logic [23:0] psn);
    beat_t b;
    wait_beats(int'(len) + 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (beats.size() == 0) break;
      b = beats.pop_front();
      if (i == 0) begin
        check("hdr_data", b.data, hdr(qp, len, raddr, psn));
        check("hdr_last", b.last, len == 8'd0);
      end else begin
        check("pay_data", b.data, pat(laddr + 32'(64 * (i - 1))));
        check("pay_last", b.last, i == int'(len));
      end
    end
    $display("pkt qp=%0d len=%0d psn=%0h done, vectors=%0d miscompares=%0d", qp, len, psn, n_vec, n_bad);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b0; bus.wr_qp = '0; bus.wr_raddr = '0; bus.wr_laddr = '0; bus.wr_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_valid", bus.axis_tx_valid, 0);
    check("rst_last", bus.axis_tx_last, 0);
    check("rst_data", bus.axis_tx_data, 0);
    check("rst_hbm_re", bus.hbm_re, 0);
    check("rst_hbm_addr", bus.hbm_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_stat_pkts", stat_pkts, 0);
    check("rst_stat_beats", stat_beats, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Header-only packets on qp 3: PSN 0 then 1.
    send(4'd3, 32'h1000_0000, 32'h0, 8'd0);
    expect_pkt(4'd3, 32'h1000_0000, 32'h0, 8'd0, 24'h0);
    send(4'd3, 32'h1000_0040, 32'h0, 8'd0);
    expect_pkt(4'd3, 32'h1000_0040, 32'h0, 8'd0, 24'h1);

    // Four-beat payload, ready held high: address sequence and latency.
    iss.delete();
    send(4'd1, 32'hABCD_0000, 32'h40, 8'd4);
    wait_beats(5);
    check("iss_count", iss.size(), 4);
    for (int i = 0; i < 4 && i < iss.size(); i++)
      check("iss_addr", iss[i].addr, 32'h40 + 32'(64 * i));
    if (iss.size() > 0) check("first_re_cyc", iss[0].cyc - acc_cyc, 1);
    if (beats.size() >= 5) begin
      check("hdr_cyc", beats[0].cyc - acc_cyc, 1);
      check("pay0_cyc", beats[1].cyc - acc_cyc, 2 + L);
      check("steady_cyc", beats[4].cyc - beats[1].cyc, 3);
    end
    expect_pkt(4'd1, 32'hABCD_0000, 32'h40, 8'd4, 24'h0);

    // Sixteen beats under random backpressure, local address wrapping past 2^32.
    rnd_mode = 1'b1;
    send(4'd2, 32'h2222_0000, 32'hFFFF_FF00, 8'd16);
    expect_pkt(4'd2, 32'h2222_0000, 32'hFFFF_FF00, 8'd16, 24'h0);
    rnd_mode = 1'b0;

    // PSN wrap on qp 0.
    @(negedge clk);
    force dut.g_psn[0].psn_entry_reg = 24'hFFFFFF;
    send(4'd0, 32'h3000_0000, 32'h0, 8'd0);
    release dut.g_psn[0].psn_entry_reg;
    expect_pkt(4'd0, 32'h3000_0000, 32'h0, 8'd0, 24'hFFFFFF);
    send(4'd0, 32'h3000_0000, 32'h0, 8'd0);
    expect_pkt(4'd0, 32'h3000_0000, 32'h0, 8'd0, 24'h0);

    // Clear coincident with a header handshake wins over the increment.
    send(4'd0, 32'h3100_0000, 32'h0, 8'd0);
    psn_clr = 1'b1;
    @(negedge clk);
    psn_clr = 1'b0;
    expect_pkt(4'd0, 32'h3100_0000, 32'h0, 8'd0, 24'h1);
    send(4'd0, 32'h3200_0000, 32'h0, 8'd0);
    expect_pkt(4'd0, 32'h3200_0000, 32'h0, 8'd0, 24'h0);
    send(4'd3, 32'h3300_0000, 32'h0, 8'd0);
    expect_pkt(4'd3, 32'h3300_0000, 32'h0, 8'd0, 24'h0);

    // Reset after two of eight payload beats; in-flight HBM data returns afterwards.
    send(4'd5, 32'h4000_0000, 32'h4000, 8'd8);
    wait_beats(3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_wr_ready", bus.wr_ready, 1);
    check("mid_valid", bus.axis_tx_valid, 0);
    check("mid_last", bus.axis_tx_last, 0);
    check("mid_data", bus.axis_tx_data, 0);
    check("mid_hbm_re", bus.hbm_re, 0);
    check("mid_hbm_addr", bus.hbm_addr, 0);
    check("mid_busy", busy, 0);
    beats.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd5, 32'h5000_0000, 32'h8000, 8'd2);
    expect_pkt(4'd5, 32'h5000_0000, 32'h8000, 8'd2, 24'h0);
    repeat (20) @(posedge clk);
    check("no_extra_beats", beats.size(), 0);

    // Counters over three two-beat-payload packets from a clean reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(4'd4, 32'h6000_0000 + 32'(k), 32'h1_0000 + 32'(k * 256), 8'd2);
      expect_pkt(4'd4, 32'h6000_0000 + 32'(k), 32'h1_0000 + 32'(k * 256), 8'd2, 24'(k));
    end
    repeat (4) @(posedge clk);
    #1;
`ifdef ROCE_TX_STATS_EN
    check("stat_pkts", stat_pkts, 3);
    check("stat_beats", stat_beats, 9);
`else
    check("stat_pkts", stat_pkts, 0);
    check("stat_beats", stat_beats, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
